// File: rtl/io_spi_master_endpoint_if.sv
// IO handshake bundle between the command controller (master) and an
// IO-domain endpoint (slave). One REQ/ACK pair carries both command
// accepts and responses.
interface io_spi_master_endpoint_if #(
    parameter int PORTBYTEWIDTH = 4
);
    localparam int W = PORTBYTEWIDTH * 8;

    logic         IOREQ;
    logic         IOACK;
    logic         IOCommandEn;
    logic         IOResponseRequested;
    logic         IOCommandResponse;
    logic         IOMemResponseFlag;
    logic         IORegResponseFlag;
    logic [3:0]   DestRegIn;
    logic [W-1:0] DataIn;
    logic [3:0]   DestRegOut;
    logic [W-1:0] DataOut;

    modport master (
        output IOREQ, IOCommandEn, IOResponseRequested, DestRegIn, DataIn,
        input  IOACK, IOCommandResponse, IOMemResponseFlag, IORegResponseFlag,
               DestRegOut, DataOut
    );

    modport slave (
        input  IOREQ, IOCommandEn, IOResponseRequested, DestRegIn, DataIn,
        output IOACK, IOCommandResponse, IOMemResponseFlag, IORegResponseFlag,
               DestRegOut, DataOut
    );
endinterface

// File: rtl/io_spi_master_endpoint.sv
// SPI master endpoint on the IO handshake. Each command shifts one byte
// out (mode 0, MSB first) while capturing one byte in, then returns the
// captured byte as a memory (store) or register (atomic load) response.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a command; CS_n may still be low from a held transfer
// SETUP | CS_n asserted, MOSI = tx[7], one half-period before first edge
// SHIFT | eight SCLK periods, low half then high half per bit
// RESP  | response presented until the controller raises IOREQ
module io_spi_master_endpoint #(
    parameter int PORTBYTEWIDTH = 4,
    parameter int CLKDIV        = 4
) (
    input  logic                      clk,
    input  logic                      async_rst,
    io_spi_master_endpoint_if.slave   io,
    output logic                      SPI_SCLK,
    output logic                      SPI_MOSI,
    output logic                      SPI_CS_n,
    input  logic                      SPI_MISO
);
    localparam int W     = PORTBYTEWIDTH * 8;
    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLKDIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic             half_q, half_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             hold_q, hold_d;
    logic             kind_q, kind_d;
    logic [3:0]       dest_q, dest_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic [W-1:0]     data_out_q, data_out_d;
    logic [3:0]       dest_out_q, dest_out_d;

    logic ack, cmd_resp, mem_flag, reg_flag;

    // Bits above the hold flag carry nothing for this device.
    logic unused_data_in;
    assign unused_data_in = ^io.DataIn[W-1:9];

    // State and datapath registers; reset aborts any transfer outright.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            half_q     <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            hold_q     <= 1'b0;
            kind_q     <= 1'b0;
            dest_q     <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            data_out_q <= '0;
            dest_out_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            half_q     <= half_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            hold_q     <= hold_d;
            kind_q     <= kind_d;
            dest_q     <= dest_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            data_out_q <= data_out_d;
            dest_out_q <= dest_out_d;
        end
    end

    // Next-state, SPI sequencing and handshake outputs.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        half_d     = half_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        hold_d     = hold_q;
        kind_d     = kind_q;
        dest_d     = dest_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        data_out_d = data_out_q;
        dest_out_d = dest_out_q;
        ack        = 1'b0;
        cmd_resp   = 1'b0;
        mem_flag   = 1'b0;
        reg_flag   = 1'b0;

        unique case (state_q)
            IDLE: begin
                ack      = 1'b1;
                cmd_resp = 1'b1;
                if (io.IOREQ && (io.IOCommandEn || io.IOResponseRequested)) begin
                    tx_d   = io.DataIn[7:0];
                    hold_d = io.DataIn[8];
                    dest_d = io.DestRegIn;
                    // Both command strobes at once is treated as an atomic load.
                    kind_d = io.IOResponseRequested;
                    mosi_d = io.DataIn[7];
                    rx_d   = '0;
                    div_d  = DIV_LOAD;
                    bit_d  = 3'd7;
                    half_d = 1'b0;
                    cs_n_d = 1'b0;
                    // With CS already held low the slave is selected; skip the setup gap.
                    state_d = cs_n_q ? SETUP : SHIFT;
                end
            end

            SETUP: begin
                if (div_q == '0) begin
                    div_d   = DIV_LOAD;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end

            SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = DIV_LOAD;
                    if (!half_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], SPI_MISO};
                        half_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        half_d = 1'b0;
                        if (bit_q == 3'd0) begin
                            cs_n_d     = ~hold_q;
                            data_out_d = {{(W-8){1'b0}}, rx_q};
                            dest_out_d = dest_q;
                            state_d    = RESP;
                        end else begin
                            bit_d  = bit_q - 3'd1;
                            mosi_d = tx_q[bit_q - 3'd1];
                        end
                    end
                end
            end

            RESP: begin
                ack      = 1'b1;
                reg_flag = kind_q;
                mem_flag = ~kind_q;
                if (io.IOREQ) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign io.IOACK             = ack & ~async_rst;
    assign io.IOCommandResponse = cmd_resp & ~async_rst;
    assign io.IOMemResponseFlag = mem_flag & ~async_rst;
    assign io.IORegResponseFlag = reg_flag & ~async_rst;
    assign io.DataOut           = data_out_q;
    assign io.DestRegOut        = dest_out_q;
    assign SPI_SCLK             = sclk_q;
    assign SPI_MOSI             = mosi_q;
    assign SPI_CS_n             = cs_n_q;
endmodule

// File: tb/tb_io_spi_master_endpoint.sv
// Directed bench for io_spi_master_endpoint: stimulus pushes expected
// responses into a scoreboard queue, a monitor pops and compares them
// whenever the device presents a response.
module tb_io_spi_master_endpoint;
    localparam int P      = 4;
    localparam int W      = P * 8;
    localparam int CLKDIV = 4;
    localparam int LAT_SETUP = 17 * CLKDIV;
    localparam int LAT_HOLD  = 16 * CLKDIV;

    logic clk = 1'b0;
    logic async_rst;
    logic sclk, mosi, cs_n, miso;
    int   miso_mode;   // 0 loopback, 1 tied high, 2 tied low

    always #5 clk = ~clk;

    io_spi_master_endpoint_if #(.PORTBYTEWIDTH(P)) io_bus ();

    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

    io_spi_master_endpoint #(.PORTBYTEWIDTH(P), .CLKDIV(CLKDIV)) dut (
        .clk       (clk),
        .async_rst (async_rst),
        .io        (io_bus),
        .SPI_SCLK  (sclk),
        .SPI_MOSI  (mosi),
        .SPI_CS_n  (cs_n),
        .SPI_MISO  (miso)
    );

    typedef struct {
        logic         reg_kind;
        logic [3:0]   dest;
        logic [W-1:0] data;
        int           lat;
        logic [7:0]   tx;
    } exp_t;

    exp_t sb_q[$];

    int         cyc = 0;
    logic [7:0] mosi_cap = 8'h00;
    int         pulses = 0;
    int         cs_rises = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         accept_cyc = 0;
    int         pulse_base = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge sclk) begin
        mosi_cap <= {mosi_cap[6:0], mosi};
        pulses   <= pulses + 1;
    end

    always @(posedge cs_n) cs_rises <= cs_rises + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [7:0] tx, input logic hold, input logic [3:0] dest,
                         input logic en, input logic rr, input logic push,
                         input logic exp_reg, input logic [7:0] exp_rx, input int exp_lat);
        int t = 0;
        @(negedge clk);
        while (!(io_bus.IOACK && io_bus.IOCommandResponse) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 64'(t < 200), 64'd1);
        if (push) sb_q.push_back('{exp_reg, dest, {{(W-8){1'b0}}, exp_rx}, exp_lat, tx});
        pulse_base = pulses;
        io_bus.IOREQ               = 1'b1;
        io_bus.IOCommandEn         = en;
        io_bus.IOResponseRequested = rr;
        io_bus.DestRegIn           = dest;
        io_bus.DataIn              = {23'h55AA3, hold, tx};
        @(posedge clk);
        @(negedge clk);
        accept_cyc = cyc;
        io_bus.IOREQ               = 1'b0;
        io_bus.IOCommandEn         = 1'b0;
        io_bus.IOResponseRequested = 1'b0;
        io_bus.DataIn              = '0;
    endtask

    task automatic complete(input int stall);
        int           t = 0;
        logic         stable;
        logic [W-1:0] d0;
        logic [3:0]   r0;
        logic [1:0]   f0;
        while (!(io_bus.IOACK && !io_bus.IOCommandResponse) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("resp_arrived", 64'(t < 300), 64'd1);
        if (stall > 0) begin
            stable = 1'b1;
            d0 = io_bus.DataOut;
            r0 = io_bus.DestRegOut;
            f0 = {io_bus.IORegResponseFlag, io_bus.IOMemResponseFlag};
            io_bus.IOCommandEn = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (io_bus.DataOut !== d0 || io_bus.DestRegOut !== r0 ||
                    {io_bus.IORegResponseFlag, io_bus.IOMemResponseFlag} !== f0 ||
                    io_bus.IOACK !== 1'b1 || io_bus.IOCommandResponse !== 1'b0)
                    stable = 1'b0;
            end
            io_bus.IOCommandEn = 1'b0;
            chk("resp_stable_during_stall", 64'(stable), 64'd1);
        end
        io_bus.IOREQ = 1'b1;
        @(negedge clk);
        if (stall > 0) begin
            chk("idle_after_resp_ack", 64'(io_bus.IOACK), 64'd1);
            chk("idle_after_resp_cmdresp", 64'(io_bus.IOCommandResponse), 64'd1);
        end
        io_bus.IOREQ = 1'b0;
    endtask

    task automatic monitor();
        logic prev = 1'b0;
        logic now_resp;
        exp_t e;
        forever begin
            @(negedge clk);
            now_resp = io_bus.IOACK && !io_bus.IOCommandResponse;
            if (now_resp && !prev) begin
                chk("resp_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("resp_reg_flag", 64'(io_bus.IORegResponseFlag), 64'(e.reg_kind));
                    chk("resp_mem_flag", 64'(io_bus.IOMemResponseFlag), 64'(!e.reg_kind));
                    chk("resp_dest", 64'(io_bus.DestRegOut), 64'(e.dest));
                    chk("resp_data", 64'(io_bus.DataOut), 64'(e.data));
                    chk("resp_latency", 64'(cyc - accept_cyc), 64'(e.lat));
                    chk("mosi_byte", 64'(mosi_cap), 64'(e.tx));
                    chk("sclk_pulses", 64'(pulses - pulse_base), 64'd8);
                end
            end
            prev = now_resp;
        end
    endtask

    task automatic stimulus();
        int t;
        int rises0;
        async_rst                  = 1'b1;
        miso_mode                  = 0;
        io_bus.IOREQ               = 1'b1;
        io_bus.IOCommandEn         = 1'b0;
        io_bus.IOResponseRequested = 1'b0;
        io_bus.DestRegIn           = '0;
        io_bus.DataIn              = '0;
        repeat (3) @(negedge clk);
        chk("rst_ioack", 64'(io_bus.IOACK), 64'd0);
        chk("rst_cmdresp", 64'(io_bus.IOCommandResponse), 64'd0);
        chk("rst_flags", 64'({io_bus.IORegResponseFlag, io_bus.IOMemResponseFlag}), 64'd0);
        chk("rst_cs_n", 64'(cs_n), 64'd1);
        chk("rst_sclk", 64'(sclk), 64'd0);
        io_bus.IOREQ = 1'b0;
        async_rst = 1'b0;
        @(negedge clk);
        chk("idle_ioack", 64'(io_bus.IOACK), 64'd1);
        chk("idle_cmdresp", 64'(io_bus.IOCommandResponse), 64'd1);
        chk("idle_flags", 64'({io_bus.IORegResponseFlag, io_bus.IOMemResponseFlag}), 64'd0);
        chk("idle_cs_n", 64'(cs_n), 64'd1);
        chk("idle_dataout", 64'(io_bus.DataOut), 64'd0);
        chk("idle_destout", 64'(io_bus.DestRegOut), 64'd0);

        // Store 0xA5, loopback
        issue(8'hA5, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, LAT_SETUP);
        complete(0);
        chk("store_cs_n_after", 64'(cs_n), 64'd1);

        // Atomic load 0x3C, MISO high
        miso_mode = 1;
        issue(8'h3C, 1'b0, 4'd7, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, LAT_SETUP);
        complete(0);

        // Held chip select across two stores
        miso_mode = 0;
        rises0 = cs_rises;
        issue(8'h5A, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, LAT_SETUP);
        complete(0);
        chk("hold_gap_cs_n", 64'(cs_n), 64'd0);
        chk("hold_gap_sclk", 64'(sclk), 64'd0);
        issue(8'hC3, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, LAT_HOLD);
        complete(0);
        chk("hold_cs_rises", 64'(cs_rises - rises0), 64'd1);
        chk("hold_cs_n_after", 64'(cs_n), 64'd1);

        // Stalled response, MISO low
        miso_mode = 2;
        issue(8'h81, 1'b0, 4'hE, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, LAT_SETUP);
        complete(10);

        // Both strobes: treated as atomic
        miso_mode = 0;
        issue(8'h0F, 1'b0, 4'h9, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0F, LAT_SETUP);
        complete(0);

        // Reset during bit 3, CS held
        issue(8'hFF, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        t = 0;
        while ((pulses - pulse_base) < 5 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reached_bit3", 64'(t < 500), 64'd1);
        async_rst = 1'b1;
        #1;
        chk("abort_cs_n", 64'(cs_n), 64'd1);
        chk("abort_sclk", 64'(sclk), 64'd0);
        chk("abort_ioack", 64'(io_bus.IOACK), 64'd0);
        @(negedge clk);
        async_rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_idle_cmdresp", 64'(io_bus.IOCommandResponse), 64'd1);
        chk("abort_dataout", 64'(io_bus.DataOut), 64'd0);
        chk("abort_cs_n_later", 64'(cs_n), 64'd1);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
